// File: rtl/RS5_pkg.sv
// Shared FFT reader types: FSM state encoding and default buffer geometry.
package RS5_pkg;

    localparam int FFT_WORDS = 32;
    localparam int FFT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } fft_rd_state_e;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational bit reversal of an index of width W.
module fft_bitrev #(
    parameter int W = 5
) (
    input  logic [W-1:0] idx,
    output logic [W-1:0] rev
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign rev[i] = idx[W-1-i];
    end

endmodule

// File: rtl/fft_ram_reader.sv
// Snapshots a parallel FFT sample buffer on start and streams it out
// word by word over a valid/ready handshake, in natural or bit-reversed order.
module fft_ram_reader
    import RS5_pkg::*;
#(
    parameter int MEMWIDTH  = FFT_WORDS,
    parameter int WORDWIDTH = FFT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          bitrev_i,
    input  logic                          abort_i,
    input  logic [MEMWIDTH*WORDWIDTH-1:0] data_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [WORDWIDTH-1:0]          data_o,
    output logic [$clog2(MEMWIDTH)-1:0]   addr_o,
    output logic                          last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int AW = $clog2(MEMWIDTH);
    localparam logic [AW-1:0] LAST = AW'(MEMWIDTH - 1);

    fft_rd_state_e state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW-1:0] idx_rev;
    logic [AW-1:0] rd_addr;
    logic          brev_q;
    logic          cap;
    logic [WORDWIDTH-1:0] snap [MEMWIDTH];

    fft_bitrev #(
        .W (AW)
    ) u_bitrev (
        .idx (idx),
        .rev (idx_rev)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            brev_q <= 1'b0;
            for (int k = 0; k < MEMWIDTH; k++) begin
                snap[k] <= '0;
            end
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (cap) begin
                brev_q <= bitrev_i;
                for (int k = 0; k < MEMWIDTH; k++) begin
                    snap[k] <= data_i[k*WORDWIDTH +: WORDWIDTH];
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cap     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    cap     = 1'b1;
                    idx_n   = '0;
                    state_n = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // abort wins over a handshake landing on the same edge
                if (abort_i) begin
                    state_n = ST_IDLE;
                end else if (ready_i) begin
                    if (idx == LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rd_addr = brev_q ? idx_rev : idx;
    assign valid_o = (state == ST_STREAM);
    assign addr_o  = valid_o ? rd_addr : '0;
    assign data_o  = valid_o ? snap[rd_addr] : '0;
    assign last_o  = valid_o && (idx == LAST);
    assign busy_o  = (state != ST_IDLE);
    assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_fft_ram_reader.sv
// Directed scoreboard bench for fft_ram_reader: natural and bit-reversed
// streams, stalls, input overwrite, abort, mid-stream reset, held start.
module tb_fft_ram_reader;

    localparam int N = 32;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           bitrev_i;
    logic           abort_i;
    logic [N*W-1:0] data_i;
    logic           ready_i;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic [4:0]     addr_o;
    logic           last_o;
    logic           busy_o;
    logic           done_o;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errs = 0;

    fft_ram_reader #(
        .MEMWIDTH  (N),
        .WORDWIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .bitrev_i (bitrev_i),
        .abort_i  (abort_i),
        .data_i   (data_i),
        .ready_i  (ready_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .addr_o   (addr_o),
        .last_o   (last_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] brev(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    task automatic load_pattern();
        for (int k = 0; k < N; k++) data_i[k*W +: W] = 16'h0100 + 16'(k);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_last"},  32'(last_o),  32'd0);
        chk({tag, "_done"},  32'(done_o),  32'd0);
        chk({tag, "_busy"},  32'(busy_o),  32'd0);
        chk({tag, "_data"},  32'(data_o),  32'd0);
        chk({tag, "_addr"},  32'(addr_o),  32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge where valid_o is due.
    task automatic kick(input bit rev, input bit with_abort);
        exp_t e;
        sb.delete();
        start_i  = 1'b1;
        bitrev_i = rev;
        abort_i  = with_abort;
        for (int k = 0; k < N; k++) begin
            e.a = rev ? brev(5'(k)) : 5'(k);
            e.d = 16'h0100 + 16'(e.a);
            sb.push_back(e);
        end
        @(negedge clk);
        start_i  = 1'b0;
        abort_i  = 1'b0;
        bitrev_i = 1'b0;
        chk("latency_valid", 32'(valid_o), 32'd1);
        chk("latency_busy",  32'(busy_o),  32'd1);
    endtask

    // mode 0: ready always; mode 1: ready 1,0,0 repeating.
    // stop_at >= 0 fires abort (or rst) when that many words have moved.
    task automatic drain(input int mode, input bit hold_start, input int stop_at,
                         input bit use_rst, output int xfers, output int cycles);
        bit stalled = 1'b0;
        bit finished = 1'b0;
        logic [15:0] pd = '0;
        logic [4:0] pa = '0;
        exp_t e;
        xfers = 0;
        cycles = 0;
        for (int c = 0; c < 400 && !finished; c++) begin
            start_i = hold_start;
            ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (sb.size() == 0 || !valid_o) begin
                chk("stream_alive", 32'(valid_o && sb.size() != 0), 32'd1);
                start_i = 1'b0;
                return;
            end
            if (stalled) begin
                chk("stall_data", 32'(data_o), 32'(pd));
                chk("stall_addr", 32'(addr_o), 32'(pa));
            end
            chk("last_flag", 32'(last_o), 32'(sb.size() == 1));
            if (xfers == stop_at) begin
                chk("stop_addr", 32'(addr_o), 32'(sb[0].a));
                ready_i = 1'b1;
                if (use_rst) rst = 1'b1;
                else abort_i = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                abort_i = 1'b0;
                start_i = 1'b0;
                sb.delete();
                return;
            end
            if (ready_i) begin
                e = sb.pop_front();
                chk("addr", 32'(addr_o), 32'(e.a));
                chk("data", 32'(data_o), 32'(e.d));
                xfers++;
            end
            stalled = !ready_i;
            pd = data_o;
            pa = addr_o;
            cycles++;
            @(negedge clk);
            if (sb.size() == 0) finished = 1'b1;
        end
        chk("drain_timeout", 32'(finished), 32'd1);
        start_i = 1'b0;
    endtask

    task automatic chk_done_tail(input string tag);
        chk({tag, "_done_pulse"}, 32'(done_o),  32'd1);
        chk({tag, "_done_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_done_busy"},  32'(busy_o),  32'd1);
        chk({tag, "_done_data"},  32'(data_o),  32'd0);
        @(negedge clk);
        chk({tag, "_post_done"},  32'(done_o),  32'd0);
        chk({tag, "_post_busy"},  32'(busy_o),  32'd0);
    endtask

    initial begin
        int x, cy;
        rst = 1'b1;
        start_i = 1'b0;
        bitrev_i = 1'b0;
        abort_i = 1'b0;
        ready_i = 1'b0;
        load_pattern();
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("idle");

        kick(1'b0, 1'b0);
        chk("first_addr", 32'(addr_o), 32'd0);
        chk("first_data", 32'(data_o), 32'h0100);
        drain(0, 1'b0, -1, 1'b0, x, cy);
        chk("nat_xfers", 32'(x), 32'd32);
        chk("nat_cycles", 32'(cy), 32'd32);
        chk_done_tail("nat");

        kick(1'b1, 1'b0);
        drain(0, 1'b0, -1, 1'b0, x, cy);
        chk("rev_xfers", 32'(x), 32'd32);
        chk_done_tail("rev");

        kick(1'b0, 1'b0);
        data_i = '1;
        drain(1, 1'b0, -1, 1'b0, x, cy);
        chk("stall_xfers", 32'(x), 32'd32);
        chk_done_tail("stall");
        load_pattern();

        kick(1'b0, 1'b0);
        drain(0, 1'b0, 5, 1'b0, x, cy);
        chk_idle_zero("abort");
        @(negedge clk);
        chk("abort_no_done", 32'(done_o), 32'd0);
        kick(1'b0, 1'b1);
        chk("restart_addr", 32'(addr_o), 32'd0);
        drain(0, 1'b0, -1, 1'b0, x, cy);
        chk("restart_xfers", 32'(x), 32'd32);
        chk_done_tail("restart");

        kick(1'b1, 1'b0);
        drain(0, 1'b0, 10, 1'b1, x, cy);
        chk_idle_zero("midrst");

        kick(1'b0, 1'b0);
        drain(1, 1'b1, -1, 1'b0, x, cy);
        chk("held_start_xfers", 32'(x), 32'd32);
        chk_done_tail("held");
        @(negedge clk);
        chk("held_no_restart", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
